// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types and helpers for the instruction-fetch front end.
//   - RESET_PC_DEFAULT : default fetch PC after reset
//   - ifu_state_e      : fetch FSM states
//   - fetch_entry_t    : one fetch-buffer entry {pc, inst, fault}
//   - pc_misaligned()  : true when a PC is not word aligned
//   - make_entry()     : builds an entry, zeroing inst for faulting fetches
package ifu_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_KILL = 2'd2,
        S_HALT = 2'd3
    } ifu_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        fault;
    } fetch_entry_t;

    function automatic logic pc_misaligned(input logic [31:0] pc);
        return (pc[1:0] != 2'b00);
    endfunction

    function automatic fetch_entry_t make_entry(input logic [31:0] pc,
                                                input logic [31:0] inst,
                                                input logic        fault);
        fetch_entry_t e;
        e.pc    = pc;
        e.inst  = fault ? 32'h0000_0000 : inst;
        e.fault = fault;
        return e;
    endfunction

endpackage

// File: rtl/ifu_fetch_fifo.sv
// ifu_fifo: synchronous fetch buffer between the fetch FSM and decode.
//   clock, reset (async active-low)
//   flush      : drop all entries (wins over a same-cycle push)
//   push/push_data : write one entry when not full
//   pop        : retire head entry when not empty
//   head       : current head entry (registered storage)
//   full/empty : occupancy flags; a pop frees a slot only from the next cycle
module ifu_fifo
    import ifu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output fetch_entry_t head,
    output logic         full,
    output logic         empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW-1:0] PTR_ZERO = AW'(0);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_ZERO = (AW + 1)'(0);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    fetch_entry_t    mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [AW:0]     count_r;
    logic            do_push_s;
    logic            do_pop_s;

    assign full      = (count_r == CNT_FULL);
    assign empty     = (count_r == CNT_ZERO);
    assign do_push_s = push && !full && !flush;
    assign do_pop_s  = pop && !empty && !flush;
    assign head      = mem_r[rd_ptr_r];

    // Pointer and occupancy tracking; flush empties the buffer outright.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else if (flush) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; cleared on reset so decode-side outputs read zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction-fetch front end.
//   clock, reset (async active-low)
//   imem_req_valid/ready/addr : one outstanding word read at the current PC
//   imem_rsp_valid/data/err   : single-cycle response, no backpressure
//   redirect_valid/pc         : flush the buffer and restart fetch at redirect_pc
//   id_valid/ready/pc/inst/fault : head of the fetch buffer toward decode
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_fault
);

    ifu_state_e   state_r;
    ifu_state_e   state_nxt_s;
    logic [31:0]  pc_r;
    logic [31:0]  pc_nxt_s;
    logic         push_s;
    fetch_entry_t push_data_s;
    logic         flush_s;
    logic         pop_s;
    fetch_entry_t head_s;
    logic         full_s;
    logic         empty_s;
    logic         req_fire_s;
    logic         rsp_owed_s;

    // Requests only go out with buffer room, so every response has a slot.
    // Gating with reset keeps the request low while reset is held.
    assign imem_req_valid = reset && (state_r == S_REQ) && !full_s && !pc_misaligned(pc_r);
    assign imem_req_addr  = pc_r;
    assign req_fire_s     = imem_req_valid && imem_req_ready;

    // No decode transfer in a redirect cycle: the head is being flushed.
    assign id_valid = !empty_s && !redirect_valid;
    assign pop_s    = id_valid && id_ready;
    assign id_pc    = head_s.pc;
    assign id_inst  = head_s.inst;
    assign id_fault = head_s.fault;

    // A response is still owed if one is in flight and not arriving now.
    assign rsp_owed_s = ((state_r == S_WAIT) && !imem_rsp_valid) ||
                        ((state_r == S_KILL) && !imem_rsp_valid) ||
                        ((state_r == S_REQ)  && req_fire_s);

    // Fetch state and PC registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= S_REQ;
            pc_r    <= RESET_PC;
        end else begin
            state_r <= state_nxt_s;
            pc_r    <= pc_nxt_s;
        end
    end

    // Next-state, PC update and buffer push/flush decisions.
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        push_s      = 1'b0;
        push_data_s = '0;
        flush_s     = 1'b0;
        if (redirect_valid) begin
            flush_s     = 1'b1;
            pc_nxt_s    = redirect_pc;
            state_nxt_s = rsp_owed_s ? S_KILL : S_REQ;
        end else begin
            case (state_r)
                S_REQ: begin
                    if (pc_misaligned(pc_r)) begin
                        if (!full_s) begin
                            push_s      = 1'b1;
                            push_data_s = make_entry(pc_r, 32'h0000_0000, 1'b1);
                            state_nxt_s = S_HALT;
                        end else begin
                            state_nxt_s = S_REQ;
                        end
                    end else if (req_fire_s) begin
                        state_nxt_s = S_WAIT;
                    end else begin
                        state_nxt_s = S_REQ;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        push_s      = 1'b1;
                        push_data_s = make_entry(pc_r, imem_rsp_data, imem_rsp_err);
                        if (imem_rsp_err) begin
                            state_nxt_s = S_HALT;
                        end else begin
                            pc_nxt_s    = pc_r + 32'd4;
                            state_nxt_s = S_REQ;
                        end
                    end else begin
                        state_nxt_s = S_WAIT;
                    end
                end
                S_KILL: begin
                    if (imem_rsp_valid) begin
                        state_nxt_s = S_REQ;
                    end else begin
                        state_nxt_s = S_KILL;
                    end
                end
                S_HALT: begin
                    state_nxt_s = S_HALT;
                end
                default: begin
                    state_nxt_s = S_REQ;
                end
            endcase
        end
    end

    ifu_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush_s),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (pop_s),
        .head      (head_s),
        .full      (full_s),
        .empty     (empty_s)
    );

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: randomized bench for ifu_fetch with a behavioural memory and
// an in-order decode-stream reference model (expected PC sequence per redirect).
module tb_ifu_fetch;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam int          DEPTH  = 2;

    logic        clock;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_fault;

    ifu_fetch #(
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .id_inst        (id_inst),
        .id_fault       (id_fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          total = 0;
    int          bad   = 0;
    // reference model of the decode stream
    logic [31:0] exp_pc;
    logic [31:0] req_exp;
    bit          exp_done;
    // memory model
    bit          mem_busy;
    int          mem_cnt;
    logic [31:0] mem_addr;
    // knobs and observations
    int          lat_min, lat_max, ready_pct, idr_pct;
    bit          chk_lat;
    bit          rsp_prev;
    int          n_fire, n_xfer, n_rsp, n_fault;
    logic [31:0] first_fire_addr;
    logic [31:0] first_xfer_pc;

    function automatic bit bad_addr(input logic [31:0] a);
        return (a < 32'h8000_0000) || (a >= 32'h8800_0000);
    endfunction

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        if (a < 32'h8000_0100) return 32'h0000_0013;
        return {a[7:0], a[31:8]} ^ 32'h1357_9bdf;
    endfunction

    task automatic model_reset();
        exp_pc   = RST_PC;
        req_exp  = RST_PC;
        exp_done = 1'b0;
        mem_busy = 1'b0;
        mem_cnt  = 0;
        mem_addr = 32'h0;
        rsp_prev = 1'b0;
    endtask

    task automatic clear_counts();
        n_fire = 0; n_xfer = 0; n_rsp = 0; n_fault = 0;
    endtask

    // One clock cycle: drive at negedge, check at negedge+1, update after posedge.
    task automatic tick(input bit do_redir, input logic [31:0] rpc);
        bit          rsp_now, fire, xfer, e_fault;
        logic [31:0] e_inst, faddr;
        @(negedge clock);
        redirect_valid = do_redir;
        redirect_pc    = do_redir ? rpc : 32'h0;
        rsp_now        = mem_busy && (mem_cnt == 0);
        imem_rsp_valid = rsp_now;
        imem_rsp_data  = rsp_now ? inst_of(mem_addr) : $urandom();
        imem_rsp_err   = rsp_now ? bad_addr(mem_addr) : ($urandom_range(0, 1) == 1);
        imem_req_ready = ($urandom_range(0, 99) < ready_pct);
        id_ready       = ($urandom_range(0, 99) < idr_pct);
        #1;
        fire  = imem_req_valid && imem_req_ready;
        xfer  = id_valid && id_ready;
        faddr = imem_req_addr;
        if (do_redir) begin
            total++;
            if (id_valid !== 1'b0) begin
                bad++;
                $display("FAIL redir_idvalid: got %b want 0", id_valid);
            end
        end
        if (chk_lat) begin
            total++;
            if (id_valid !== rsp_prev) begin
                bad++;
                $display("FAIL rsp_to_id_latency: id_valid=%b want %b", id_valid, rsp_prev);
            end
        end
        if (fire) begin
            total++;
            if (faddr !== req_exp) begin
                bad++;
                $display("FAIL req_addr: got %h want %h", faddr, req_exp);
            end
            if (n_fire == 0) first_fire_addr = faddr;
            n_fire++;
            req_exp = req_exp + 32'd4;
        end
        if (xfer) begin
            e_fault = (exp_pc[1:0] != 2'b00) || bad_addr(exp_pc);
            e_inst  = e_fault ? 32'h0 : inst_of(exp_pc);
            total++;
            if (exp_done || id_pc !== exp_pc || id_inst !== e_inst || id_fault !== e_fault) begin
                bad++;
                $display("FAIL decode_entry: got pc=%h inst=%h fault=%b want pc=%h inst=%h fault=%b extra=%0d",
                         id_pc, id_inst, id_fault, exp_pc, e_inst, e_fault, exp_done);
            end
            if (n_xfer == 0) first_xfer_pc = id_pc;
            n_xfer++;
            if (id_fault === 1'b1) n_fault++;
            if (e_fault) exp_done = 1'b1;
            exp_pc = exp_pc + 32'd4;
        end
        if (do_redir) begin
            exp_pc   = rpc;
            req_exp  = rpc;
            exp_done = 1'b0;
        end
        @(posedge clock);
        rsp_prev = rsp_now;
        if (rsp_now) begin
            mem_busy = 1'b0;
            n_rsp++;
        end else if (mem_busy) begin
            mem_cnt--;
        end
        if (fire) begin
            mem_busy = 1'b1;
            mem_addr = faddr;
            mem_cnt  = $urandom_range(lat_min, lat_max) - 1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        imem_rsp_err = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; id_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clock);
        @(negedge clock); #1;
        total += 6;
        if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL rst_req_valid: got %b want 0", imem_req_valid); end
        if (imem_req_addr !== RST_PC) begin bad++; $display("FAIL rst_req_addr: got %h want %h", imem_req_addr, RST_PC); end
        if (id_valid !== 1'b0) begin bad++; $display("FAIL rst_id_valid: got %b want 0", id_valid); end
        if (id_pc !== 32'h0) begin bad++; $display("FAIL rst_id_pc: got %h want 0", id_pc); end
        if (id_inst !== 32'h0) begin bad++; $display("FAIL rst_id_inst: got %h want 0", id_inst); end
        if (id_fault !== 1'b0) begin bad++; $display("FAIL rst_id_fault: got %b want 0", id_fault); end
        reset = 1'b1;
        #1;
        total++;
        if (imem_req_valid !== 1'b1) begin bad++; $display("FAIL release_req_valid: got %b want 1", imem_req_valid); end
    endtask

    task automatic test_basic();
        lat_min = 1; lat_max = 1; ready_pct = 100; idr_pct = 100;
        clear_counts();
        chk_lat = 1'b1;
        repeat (20) tick(1'b0, 32'h0);
        chk_lat = 1'b0;
        total += 2;
        if (n_xfer != 9) begin bad++; $display("FAIL basic_xfers: got %0d want 9", n_xfer); end
        if (n_fire != 10) begin bad++; $display("FAIL basic_fires: got %0d want 10", n_fire); end
    endtask

    task automatic test_stall();
        lat_min = 1; lat_max = 1; ready_pct = 100; idr_pct = 0;
        repeat (10) tick(1'b0, 32'h0);
        #1;
        total += 2;
        if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL stall_req_valid: got %b want 0", imem_req_valid); end
        if (id_valid !== 1'b1) begin bad++; $display("FAIL stall_id_valid: got %b want 1", id_valid); end
        ready_pct = 0; idr_pct = 100;
        clear_counts();
        repeat (6) tick(1'b0, 32'h0);
        total++;
        if (n_xfer != DEPTH) begin bad++; $display("FAIL stall_buffered: got %0d want %0d", n_xfer, DEPTH); end
        ready_pct = 100;
    endtask

    task automatic test_redirect_wait();
        int b;
        lat_min = 3; lat_max = 3; ready_pct = 100; idr_pct = 100;
        clear_counts();
        b = 0;
        while (n_fire == 0 && b < 50) begin tick(1'b0, 32'h0); b++; end
        total++;
        if (n_fire == 0) begin bad++; $display("FAIL rw_no_request: got 0 requests want >0"); end
        tick(1'b1, 32'h8000_0100);
        clear_counts();
        b = 0;
        while (n_xfer == 0 && b < 40) begin tick(1'b0, 32'h0); b++; end
        total += 2;
        if (n_fire == 0 || first_fire_addr !== 32'h8000_0100) begin
            bad++; $display("FAIL rw_next_req: got %h (n=%0d) want 80000100", first_fire_addr, n_fire);
        end
        if (n_xfer == 0 || first_xfer_pc !== 32'h8000_0100) begin
            bad++; $display("FAIL rw_first_entry: got %h (n=%0d) want 80000100", first_xfer_pc, n_xfer);
        end
    endtask

    task automatic test_misaligned();
        lat_min = 1; lat_max = 2; ready_pct = 100; idr_pct = 100;
        tick(1'b1, 32'h8000_0102);
        clear_counts();
        repeat (20) tick(1'b0, 32'h0);
        #1;
        total += 5;
        if (n_xfer != 1) begin bad++; $display("FAIL mis_entries: got %0d want 1", n_xfer); end
        if (n_fault != 1) begin bad++; $display("FAIL mis_faults: got %0d want 1", n_fault); end
        if (first_xfer_pc !== 32'h8000_0102) begin bad++; $display("FAIL mis_pc: got %h want 80000102", first_xfer_pc); end
        if (n_fire != 0) begin bad++; $display("FAIL mis_requests: got %0d want 0", n_fire); end
        if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL mis_halt_req: got %b want 0", imem_req_valid); end
    endtask

    task automatic test_err();
        lat_min = 1; lat_max = 2; ready_pct = 100; idr_pct = 100;
        tick(1'b1, 32'h8800_0004);
        clear_counts();
        repeat (20) tick(1'b0, 32'h0);
        total += 3;
        if (n_xfer != 1) begin bad++; $display("FAIL err_entries: got %0d want 1", n_xfer); end
        if (n_fault != 1) begin bad++; $display("FAIL err_faults: got %0d want 1", n_fault); end
        if (n_fire != 1) begin bad++; $display("FAIL err_requests: got %0d want 1", n_fire); end
        tick(1'b1, 32'h8000_0000);
        clear_counts();
        repeat (20) tick(1'b0, 32'h0);
        total += 2;
        if (n_xfer < 4) begin bad++; $display("FAIL err_resume: got %0d entries want >=4", n_xfer); end
        if (n_fault != 0) begin bad++; $display("FAIL err_resume_fault: got %0d want 0", n_fault); end
    endtask

    task automatic test_random();
        logic [31:0] rpc;
        int          sel;
        lat_min = 1; lat_max = 3; ready_pct = 70; idr_pct = 60;
        clear_counts();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) < 4) begin
                sel = $urandom_range(0, 9);
                if (sel == 0)      rpc = 32'h8000_0000 + {22'h0, 8'($urandom_range(0, 255)), 2'b10};
                else if (sel == 1) rpc = 32'h87ff_fff0 + {28'h0, 2'($urandom_range(0, 3)), 2'b00};
                else               rpc = 32'h8000_0000 + {22'h0, 8'($urandom_range(0, 255)), 2'b00};
                tick(1'b1, rpc);
            end else begin
                tick(1'b0, 32'h0);
            end
        end
        total++;
        if (n_xfer < 100) begin bad++; $display("FAIL rand_progress: got %0d entries want >=100", n_xfer); end
    endtask

    task automatic test_reset_mid();
        int b;
        lat_min = 4; lat_max = 4; ready_pct = 100; idr_pct = 100;
        tick(1'b1, 32'h8000_0040);
        clear_counts();
        b = 0;
        while (n_fire == 0 && b < 50) begin tick(1'b0, 32'h0); b++; end
        tick(1'b0, 32'h0);
        @(negedge clock);
        redirect_valid = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
        reset = 1'b0;
        #1;
        total += 4;
        if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL rmid_req_valid: got %b want 0", imem_req_valid); end
        if (imem_req_addr !== RST_PC) begin bad++; $display("FAIL rmid_req_addr: got %h want %h", imem_req_addr, RST_PC); end
        if (id_valid !== 1'b0) begin bad++; $display("FAIL rmid_id_valid: got %b want 0", id_valid); end
        if (id_pc !== 32'h0) begin bad++; $display("FAIL rmid_id_pc: got %h want 0", id_pc); end
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        model_reset();
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hdead_beef; imem_rsp_err = 1'b0;
        @(negedge clock);
        imem_rsp_valid = 1'b0;
        #1;
        total += 3;
        if (id_valid !== 1'b0) begin bad++; $display("FAIL rmid_late_rsp: id_valid=%b want 0", id_valid); end
        if (imem_req_valid !== 1'b1) begin bad++; $display("FAIL rmid_restart_valid: got %b want 1", imem_req_valid); end
        if (imem_req_addr !== RST_PC) begin bad++; $display("FAIL rmid_restart_addr: got %h want %h", imem_req_addr, RST_PC); end
        clear_counts();
        repeat (30) tick(1'b0, 32'h0);
        total += 2;
        if (n_xfer < 3) begin bad++; $display("FAIL rmid_resume: got %0d entries want >=3", n_xfer); end
        if (first_xfer_pc !== RST_PC) begin bad++; $display("FAIL rmid_first_pc: got %h want %h", first_xfer_pc, RST_PC); end
    endtask

    initial begin
        chk_lat = 1'b0;
        first_fire_addr = 32'h0;
        first_xfer_pc = 32'h0;
        clear_counts();
        test_reset();
        test_basic();
        test_stall();
        test_redirect_wait();
        test_misaligned();
        test_err();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction-fetch front end of the NPC core. Owns the architectural fetch PC, issues one instruction-memory read at a time over a valid/ready request and valid-only response channel, and buffers fetched words in a small FIFO feeding the decode stage. Sits between the PC-redirect sources (branch/jump/trap from EXU/WBU) and the IF/ID boundary; the instruction-memory model or cache sits on its request/response side.

## Interface
- RESET_PC, 32'h8000_0000, PC loaded on reset
- FIFO_DEPTH, 2, fetch buffer entries (power of two, ≥2)

- clock  in  1  core clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- imem_req_valid  out  1  read request valid
- imem_req_ready  in  1  memory accepts request this cycle
- imem_req_addr  out  32  word address (current PC)
- imem_rsp_valid  in  1  response valid (single cycle, no backpressure)
- imem_rsp_data  in  32  instruction word
- imem_rsp_err  in  1  access fault (address outside 0x8000_0000..0x8800_0000)
- redirect_valid  in  1  flush and restart fetch
- redirect_pc  in  32  new fetch PC
- id_valid  out  1  decode entry valid
- id_ready  in  1  decode consumes entry
- id_pc  out  32  PC of entry
- id_inst  out  32  instruction (0 when id_fault)
- id_fault  out  1  fetch fault (misaligned or access error)

## Operation
- State machine: S_REQ, S_WAIT, S_KILL, S_HALT. Reset: S_REQ, pc=RESET_PC, FIFO empty, all outputs 0 except imem_req_addr=RESET_PC.
- S_REQ: if pc[1:0]≠0 → push {pc, 0, fault=1} (when FIFO not full), go S_HALT, no request. Else imem_req_valid = FIFO not full; on valid&ready → S_WAIT. imem_req_addr = pc.
- S_WAIT: on imem_rsp_valid push {pc, data, err}; err=1 → S_HALT (inst pushed as 0); else pc += 4 (mod 2^32), → S_REQ. FIFO space is guaranteed because requests only issue when not full.
- S_KILL: response for a flushed request pending; on imem_rsp_valid discard, → S_REQ.
- S_HALT: no requests until redirect.
- Redirect (highest priority, any state): FIFO flushed, pc ← redirect_pc; next state S_KILL if a response is still owed (S_WAIT without rsp this cycle, S_KILL without rsp this cycle, or S_REQ with req handshake this cycle), else S_REQ. id_valid forced 0 in the redirect cycle (no decode transfer).
- Redirect in S_REQ without handshake withdraws the request; memory tolerates non-sticky valid only in this case. Otherwise valid/addr held until ready.
- imem_rsp_valid outside S_WAIT/S_KILL ignored.
- Decode handshake: id_* driven from FIFO head; pop on id_valid&id_ready. Push and pop in the same cycle allowed, including when full (pop frees slot the following cycle only).

## Timing
- Request to response: ≥1 cycle (response accepted earliest cycle after req handshake).
- Response to id_valid: 1 cycle (registered FIFO).
- Peak throughput: 1 instruction / 2 cycles with a 1-cycle memory.
- Redirect to new request: next cycle if nothing owed, else cycle after discarded response.
- Reset deasserted: imem_req_valid=1 in first cycle.

## Structure
- Package ifu_pkg: RESET_PC default, state enum, fetch-entry typedef {pc[31:0], inst[31:0], fault}.
- Sub-module ifu_fifo: synchronous FIFO, FIFO_DEPTH entries, push/pop/flush, full/empty; flush wins over push.

## Test plan
- Reset release, 1-cycle memory returning 0x00000013 → requests at 0x80000000, 0x80000004, …; id_pc/inst match, id_valid one cycle after each response.
- id_ready=0 for 10 cycles → exactly FIFO_DEPTH entries buffered, imem_req_valid low while full, no loss on release.
- Redirect to 0x80000100 while S_WAIT → old response discarded, next request 0x80000100, no stale id_valid.
- Redirect to 0x80000102 → no request, one entry id_fault=1, id_pc=0x80000102, fetch halts until next redirect.
- imem_rsp_err on 0x88000004 → entry fault=1, inst=0, halt; redirect 0x80000000 resumes.
- Reset asserted mid-S_WAIT → outputs cleared immediately, fetch restarts at RESET_PC, late response ignored.
